regwb_arbiter: RTL

Write-port arbiter and sequencer for the 32x32 register file. Three writeback sources share the register file's single write port: jump-and-link, load return, and ALU result. Each source feeds a one-deep holding slot. A fixed-priority arbiter with anti-starvation aging drains the slots into a registered write port (WriteReg/WriteData/RegWrite), which connects directly to the register file. The arbiter also exports a pending-destination mask so the issue logic can stall on read-after-write hazards.

---
 rtl/regwb_pkg.sv | 26 ++
 rtl/wb_slot.sv | 47 ++++
 rtl/regwb_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/regwb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
`default_nettype none

package regwb_pkg;

  localparam int SLOT_DATA_W = 32;
  localparam int SLOT_ADDR_W = 5;
  localparam int AGE_W       = 3;

  localparam int SRC_LINK = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_ALU  = 2;
  localparam int NSRC     = 3;

  localparam logic [SLOT_ADDR_W-1:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic                   full;
    logic [SLOT_ADDR_W-1:0] dest;
    logic [SLOT_DATA_W-1:0] data;
    logic [AGE_W-1:0]       age;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/wb_slot.sv
// One-deep writeback holding slot with a saturating wait-age counter.
`default_nettype none

module wb_slot
  import regwb_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   accept,
  input  logic                   grant,
  input  logic [SLOT_ADDR_W-1:0] new_dest,
  input  logic [SLOT_DATA_W-1:0] new_data,
  output logic                   full,
  output logic                   aged,
  output logic [SLOT_ADDR_W-1:0] dest,
  output logic [SLOT_DATA_W-1:0] data
);

  slot_t slot;

  // A refill in the same cycle as a grant starts the new entry with a fresh age.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot <= '0;
    end else if (accept) begin
      slot.full <= 1'b1;
      slot.dest <= new_dest;
      slot.data <= new_data;
      slot.age  <= '0;
    end else if (grant) begin
      slot.full <= 1'b0;
      slot.age  <= '0;
    end else if (slot.full && (slot.age != '1)) begin
      slot.age <= slot.age + AGE_W'(1);
    end
  end

  assign full = slot.full;
  assign aged = slot.full && (slot.age >= AGE_W'(AGE_LIMIT));
  assign dest = slot.dest;
  assign data = slot.data;

endmodule

`default_nettype wire

// File: rtl/regwb_arbiter.sv
// Three-source writeback arbiter driving the register file's single write port,
// with aging-based anti-starvation and a pending-destination hazard mask.
`default_nettype none

module regwb_arbiter
  import regwb_pkg::*;
#(
  parameter int DATA_W    = SLOT_DATA_W,
  parameter int ADDR_W    = SLOT_ADDR_W,
  parameter int AGE_LIMIT = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 LinkValid,
  input  logic [DATA_W-1:0]    LinkPc,
  output logic                 LinkReady,
  input  logic                 LoadValid,
  output logic                 LoadReady,
  input  logic [ADDR_W-1:0]    LoadReg,
  input  logic [DATA_W-1:0]    LoadData,
  input  logic                 AluValid,
  output logic                 AluReady,
  input  logic [ADDR_W-1:0]    AluReg,
  input  logic [DATA_W-1:0]    AluData,
  output logic [ADDR_W-1:0]    WriteReg,
  output logic [DATA_W-1:0]    WriteData,
  output logic                 RegWrite,
  output logic [2**ADDR_W-1:0] Pending
);

  logic [NSRC-1:0]   valid;
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   accept;
  logic [NSRC-1:0]   full;
  logic [NSRC-1:0]   aged;
  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   grant;
  logic [ADDR_W-1:0] new_dest  [NSRC];
  logic [DATA_W-1:0] new_data  [NSRC];
  logic [ADDR_W-1:0] slot_dest [NSRC];
  logic [DATA_W-1:0] slot_data [NSRC];
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;

  assign valid[SRC_LINK]    = LinkValid;
  assign valid[SRC_LOAD]    = LoadValid;
  assign valid[SRC_ALU]     = AluValid;
  assign new_dest[SRC_LINK] = LINK_REG;
  assign new_data[SRC_LINK] = LinkPc + DATA_W'(1);
  assign new_dest[SRC_LOAD] = LoadReg;
  assign new_data[SRC_LOAD] = LoadData;
  assign new_dest[SRC_ALU]  = AluReg;
  assign new_data[SRC_ALU]  = AluData;

  assign ready     = ~full | grant;
  assign LinkReady = ready[SRC_LINK];
  assign LoadReady = ready[SRC_LOAD];
  assign AluReady  = ready[SRC_ALU];

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_slot
      // Register-0 writes complete the handshake but never occupy the slot.
      assign accept[s] = valid[s] && ready[s] && (new_dest[s] != '0);

      wb_slot #(
        .AGE_LIMIT (AGE_LIMIT)
      ) u_slot (
        .Clk      (Clk),
        .Reset    (Reset),
        .accept   (accept[s]),
        .grant    (grant[s]),
        .new_dest (new_dest[s]),
        .new_data (new_data[s]),
        .full     (full[s]),
        .aged     (aged[s]),
        .dest     (slot_dest[s]),
        .data     (slot_data[s])
      );
    end
  endgenerate

  // Aged slots form the candidate set when any exist; lowest index wins.
  assign cand  = (|aged) ? aged : full;
  assign grant = cand & (~cand + NSRC'(1));

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (grant[s]) begin
        sel_dest = slot_dest[s];
        sel_data = slot_data[s];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (|grant) begin
      RegWrite  <= 1'b1;
      WriteReg  <= sel_dest;
      WriteData <= sel_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  always_comb begin
    Pending = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (full[s]) Pending[slot_dest[s]] = 1'b1;
    end
    if (RegWrite) Pending[WriteReg] = 1'b1;
  end

endmodule

`default_nettype wire
